input_port_ctrl: RTL

Responder side of the processor's user-input path: it supplies the 20-bit `sinalInput` value the datapath consumes on an IN-type instruction. While a request is pending it stalls the processor until the operator confirms the switch value with a debounced ENTER press. It then presents the captured value with stall released for exactly one cycle, so the single-cycle core writes it back and advances the PC. It sits between the board switches/button and `ProcessadorFinal`; its stall output is ORed into the PC hold path alongside `halt`.

---
 rtl/input_port_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/input_port_ctrl.sv
// input_port_ctrl: operator input responder for the IN instruction.
// Stalls the core until a debounced ENTER rise captures the switches.
module input_port_ctrl #(
  parameter int DATA_WIDTH      = 20,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_req,
  input  logic [DATA_WIDTH-1:0] switches,
  input  logic                  btn_enter,
  output logic [DATA_WIDTH-1:0] sinal_input,
  output logic                  stall,
  output logic                  in_done,
  output logic                  waiting
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      sync_q;
  logic            btn_sync;
  logic            db_level;
  logic            db_rise;
  logic [CW-1:0]   db_cnt;
  logic            mismatch;
  logic            db_hit;
  logic            capture;

  assign btn_sync = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_enter};
    end
  end

  // level flips only after DEBOUNCE_CYCLES straight mismatching samples
  assign mismatch = (btn_sync != db_level);
  assign db_hit   = mismatch && (db_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
      db_rise  <= 1'b0;
    end else begin
      db_rise <= db_hit & btn_sync;
      if (!mismatch || db_hit) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
      if (db_hit) begin
        db_level <= btn_sync;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_req) state_d = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!in_req) begin
          state_d = IDLE;
        end else if (db_rise) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sinal_input <= '0;
    end else if (capture) begin
      sinal_input <= switches;
    end
  end

  assign stall   = in_req & (state_q != DONE) & ~reset;
  assign in_done = (state_q == DONE);
  assign waiting = (state_q == WAIT_PRESS);

endmodule
